mmio_responder: RTL

- Memory-mapped I/O responder on the processor data-memory bus, in parallel with dmem.
- Claims a 4-word address window. Inside the window it blocks dmem writes and returns its own read data with the same 1-cycle registered latency as dmem.
- Provides a transmit byte FIFO drained by an external valid/ready consumer, a status register, a free-running cycle counter and a scratch register.

---
 rtl/mmio_responder.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/mmio_responder.sv
// mmio_responder
//   Memory-mapped I/O responder sitting beside dmem on the processor data bus.
//   It claims a 4-word window at IO_BASE, suppresses dmem writes inside it and
//   returns its own registered read data with dmem's 1-cycle latency.
//
//   Register map (word offset inside the window):
//     0 TXDATA  : write pushes data[7:0]; read returns the head byte (0 if empty)
//     1 STATUS  : [0] empty, [1] full, [2] overflow (sticky, write 1 to clear),
//                 [15:8] count
//     2 CYCLES  : free-running cycle counter, writable
//     3 SCRATCH : plain 32-bit register
//
//   Ports:
//     clock      in   clock, rising edge
//     reset      in   asynchronous active-low reset
//     address    in   processor data word address
//     data       in   processor write data
//     wren       in   processor write enable
//     dmem_wren  out  write enable forwarded to dmem (masked inside the window)
//     io_sel     out  registered: q_io, not dmem q, is this cycle's read data
//     q_io       out  registered read data
//     tx_data    out  TX FIFO head byte (0 when empty)
//     tx_valid   out  TX FIFO non-empty
//     tx_ready   in   consumer accepts the head byte
module mmio_responder #(
  parameter logic [11:0] IO_BASE = 12'hF00,
  parameter int unsigned DEPTH   = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [11:0] address,
  input  logic [31:0] data,
  input  logic        wren,
  output logic        dmem_wren,
  output logic        io_sel,
  output logic [31:0] q_io,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    OFS_TXDATA  = 2'd0,
    OFS_STATUS  = 2'd1,
    OFS_CYCLES  = 2'd2,
    OFS_SCRATCH = 2'd3
  } offset_e;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic [31:0]   cycles_q, cycles_d;
  logic [31:0]   scratch_q, scratch_d;
  logic          io_sel_q;
  logic [31:0]   q_io_q, q_io_d;

  logic          hit;
  offset_e       offset;
  logic          wr_hit;
  logic          full;
  logic          empty;
  logic          push_req;
  logic          push_ok;
  logic          pop;
  logic          ovf_set;
  logic          ovf_clr;
  logic [7:0]    head;
  logic [31:0]   status_w;

  assign hit       = (address[11:2] == IO_BASE[11:2]);
  assign offset    = offset_e'(address[1:0]);
  assign wr_hit    = wren & hit;
  assign dmem_wren = wren & ~hit;

  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign tx_valid = ~empty;
  // Gate the head so a drained FIFO shows 0 rather than a stale entry.
  assign head     = empty ? 8'h00 : mem_q[rd_ptr_q];
  assign tx_data  = head;

  assign push_req = wr_hit & (offset == OFS_TXDATA);
  assign pop      = tx_valid & tx_ready;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign push_ok  = push_req & (~full | pop);
  assign ovf_set  = push_req & ~push_ok;
  assign ovf_clr  = wr_hit & (offset == OFS_STATUS) & data[2];

  assign status_w = {16'h0000, 8'(count_q), 5'b00000, ovf_q, full, empty};

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    ovf_d     = ovf_q;
    cycles_d  = cycles_q + 32'd1;
    scratch_d = scratch_q;
    q_io_d    = '0;

    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)     rd_ptr_d = rd_ptr_q + AW'(1);

    unique case ({push_ok, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    if (ovf_set)      ovf_d = 1'b1;
    else if (ovf_clr) ovf_d = 1'b0;

    if (wr_hit && offset == OFS_CYCLES)  cycles_d  = data;
    if (wr_hit && offset == OFS_SCRATCH) scratch_d = data;

    if (hit) begin
      unique case (offset)
        OFS_TXDATA:  q_io_d = {24'h000000, head};
        OFS_STATUS:  q_io_d = status_w;
        OFS_CYCLES:  q_io_d = cycles_q;
        OFS_SCRATCH: q_io_d = scratch_q;
        default:     q_io_d = '0;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      cycles_q  <= '0;
      scratch_q <= '0;
      io_sel_q  <= 1'b0;
      q_io_q    <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      cycles_q  <= cycles_d;
      scratch_q <= scratch_d;
      io_sel_q  <= hit;
      q_io_q    <= q_io_d;
    end
  end

  // Storage needs no reset: the cleared count hides every entry.
  always_ff @(posedge clock) begin
    if (push_ok) mem_q[wr_ptr_q] <= data[7:0];
  end

  assign io_sel = io_sel_q;
  assign q_io   = q_io_q;

endmodule
